ycrcb2rgb: RTL and testbench

- Pipelined colour-space converter that maps 24-bit YCbCr pixels (JFIF full-range, 8 bits per component) back to 24-bit RGB.
- Inverse of the encoder's rgb2ycrcb stage. Used on the decoder/reconstruction path and as a round-trip checker in encoder verification.
- Fully pipelined: accepts one pixel per clock, fixed 3-cycle latency, same enable/enable_out strobe protocol as rgb2ycrcb.

---
 rtl/ycrcb2rgb.sv | 112 +++++++++++
 tb/tb_ycrcb2rgb.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ycrcb2rgb.sv
// ycrcb2rgb: JFIF full-range YCbCr -> RGB converter, 8 bits per component.
// Three register stages, one pixel per clock, Q13 fixed-point coefficients.
//
// Strobe protocol: data_in is taken on any rising edge where enable=1 and
// rst=0. Exactly one enable_out pulse follows each accepted pixel, in order,
// three register stages later. There is no backpressure, so the consumer
// must take data_out on every cycle where enable_out=1. Between pulses,
// data_out holds the last converted pixel.
module ycrcb2rgb (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] data_in,
  output logic [23:0] data_out,
  output logic        enable_out
);

  // Q13 coefficients
  localparam logic signed [23:0] KR   = 24'sd11485;  // 1.402
  localparam logic signed [23:0] KGB  = 24'sd2819;   // 0.344136
  localparam logic signed [23:0] KGR  = 24'sd5850;   // 0.714136
  localparam logic signed [23:0] KB   = 24'sd14516;  // 1.772
  localparam logic signed [23:0] HALF = 24'sd4096;   // round-half-up

  // Stage 1 registers
  logic [7:0]        y1;
  logic signed [8:0] cb1;
  logic signed [8:0] cr1;
  logic              v1;

  // Stage 2 registers
  logic signed [23:0] ys2;
  logic signed [23:0] pr2;
  logic signed [23:0] pgb2;
  logic signed [23:0] pgr2;
  logic signed [23:0] pb2;
  logic               v2;

  // Stage 3 combinational sums
  logic signed [23:0] r_acc;
  logic signed [23:0] g_acc;
  logic signed [23:0] b_acc;

  // Sign-extend a 9-bit chroma offset to the accumulator width.
  function automatic logic signed [23:0] sext9(input logic signed [8:0] x);
    return $signed({{15{x[8]}}, x});
  endfunction

  // Arithmetic shift right by 13 then saturate to 0..255.
  function automatic logic [7:0] clamp8(input logic signed [23:0] acc);
    logic [10:0] q;
    q = acc[23:13];
    if (q[10])          return 8'd0;
    else if (|q[9:8])   return 8'd255;
    else                return q[7:0];
  endfunction

  // Stage 1: capture Y and remove the chroma offset.
  always_ff @(posedge clk) begin
    if (rst) begin
      y1  <= '0;
      cb1 <= '0;
      cr1 <= '0;
      v1  <= 1'b0;
    end else begin
      y1  <= data_in[7:0];
      cb1 <= $signed({1'b0, data_in[15:8]}) - 9'sd128;
      cr1 <= $signed({1'b0, data_in[23:16]}) - 9'sd128;
      v1  <= enable;
    end
  end

  // Stage 2: register the four coefficient products and Y scaled to Q13.
  always_ff @(posedge clk) begin
    if (rst) begin
      ys2  <= '0;
      pr2  <= '0;
      pgb2 <= '0;
      pgr2 <= '0;
      pb2  <= '0;
      v2   <= 1'b0;
    end else begin
      ys2  <= $signed({3'b000, y1, 13'b0});
      pr2  <= KR  * sext9(cr1);
      pgb2 <= KGB * sext9(cb1);
      pgr2 <= KGR * sext9(cr1);
      pb2  <= KB  * sext9(cb1);
      v2   <= v1;
    end
  end

  // Stage 3 sums; 24 bits signed covers the worst case without overflow.
  always_comb begin
    r_acc = ys2 + pr2 + HALF;
    g_acc = ys2 - pgb2 - pgr2 + HALF;
    b_acc = ys2 + pb2 + HALF;
  end

  // Stage 3: round, clamp and register the output; hold data_out when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      enable_out <= 1'b0;
    end else begin
      enable_out <= v2;
      if (v2) begin
        data_out <= {clamp8(b_acc), clamp8(g_acc), clamp8(r_acc)};
      end
    end
  end

endmodule

// File: tb/tb_ycrcb2rgb.sv
// Testbench for ycrcb2rgb: scoreboard of expected pixels plus a strobe
// timing model, exercised by one task per scenario.
module tb_ycrcb2rgb;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [23:0] data_in;
  logic [23:0] data_out;
  logic        enable_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] exp_q[$];
  logic [23:0] rgb_q[$];
  logic [2:0]  vp = 3'b000;
  bit          mon_on = 1'b0;
  logic [23:0] last_exp = '0;

  ycrcb2rgb dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .data_in    (data_in),
    .data_out   (data_out),
    .enable_out (enable_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, required completion", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference models ----------------
  function automatic logic [7:0] sat8(input int v);
    if (v < 0)        return 8'd0;
    else if (v > 255) return 8'd255;
    else              return v[7:0];
  endfunction

  // {Cr,Cb,Y} -> {B,G,R}, Q13 reference
  function automatic logic [23:0] model(input logic [23:0] d);
    int y, cb, cr, r, g, b;
    y  = int'(d[7:0]);
    cb = int'(d[15:8]) - 128;
    cr = int'(d[23:16]) - 128;
    r  = (y * 8192 + 11485 * cr + 4096) >>> 13;
    g  = (y * 8192 - 2819 * cb - 5850 * cr + 4096) >>> 13;
    b  = (y * 8192 + 14516 * cb + 4096) >>> 13;
    return {sat8(b), sat8(g), sat8(r)};
  endfunction

  // Forward JFIF encoder, {B,G,R} -> {Cr,Cb,Y}
  function automatic logic [23:0] forward(input logic [23:0] p);
    int r, g, b, y, cb, cr;
    r  = int'(p[7:0]);
    g  = int'(p[15:8]);
    b  = int'(p[23:16]);
    y  = (2449 * r + 4809 * g + 934 * b + 4096) >>> 13;
    cb = (-1382 * r - 2714 * g + 4096 * b + 128 * 8192 + 4096) >>> 13;
    cr = (4096 * r - 3430 * g - 666 * b + 128 * 8192 + 4096) >>> 13;
    return {sat8(cr), sat8(cb), sat8(y)};
  endfunction

  function automatic int absdiff(input logic [7:0] a, input logic [7:0] b);
    int d;
    d = int'(a) - int'(b);
    return (d < 0) ? -d : d;
  endfunction

  // ---------------- strobe timing model ----------------
  always @(posedge clk) begin
    if (rst) vp <= 3'b000;
    else     vp <= {vp[1:0], enable};
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic [23:0] e;
    logic [23:0] o;
    int tol;
    if (mon_on) begin
      n_checks++;
      if (enable_out !== vp[2]) begin
        n_fail++;
        $display("FAIL strobe_timing: enable_out=%b required %b at %0t", enable_out, vp[2], $time);
      end
      if (enable_out === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: data_out=%06h with empty expected queue", data_out);
        end else begin
          e = exp_q.pop_front();
          last_exp = e;
          if (data_out !== e) begin
            n_fail++;
            $display("FAIL pixel: data_out=%06h required %06h at %0t", data_out, e, $time);
          end
          if (rgb_q.size() > 0) begin
            o = rgb_q.pop_front();
            tol = (o == 24'h000000 || o == 24'hFFFFFF) ? 0 : 3;
            n_checks++;
            if (absdiff(data_out[7:0], o[7:0]) > tol ||
                absdiff(data_out[15:8], o[15:8]) > tol ||
                absdiff(data_out[23:16], o[23:16]) > tol) begin
              n_fail++;
              $display("FAIL round_trip: data_out=%06h original %06h tolerance %0d", data_out, o, tol);
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic [23:0] d);
    @(posedge clk);
    #1;
    enable  = en;
    data_in = d;
    if (en) exp_q.push_back(model(d));
  endtask

  task automatic drive_const(input logic [23:0] d, input logic [23:0] e);
    @(posedge clk);
    #1;
    enable  = 1'b1;
    data_in = d;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) drive(1'b0, 24'h0);
    drive(1'b0, 24'h0);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d pixels outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (enable_out !== 1'b0 || data_out !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_state: enable_out=%b data_out=%06h required 0/000000", enable_out, data_out);
    end
    mon_on = 1'b1;
  endtask

  task automatic test_gray();
    drive_const(24'h808000, 24'h000000);
    drive(1'b0, 24'h0);
    drive_const(24'h8080FF, 24'hFFFFFF);
    drive(1'b0, 24'h0);
    drive(1'b0, 24'h0);
    drive_const(24'h808080, 24'h808080);
    drain();
  endtask

  task automatic test_clamp();
    drive_const(24'hFF554C, 24'h0000FE);
    drive_const(24'hFF80FF, 24'hFFA4FF);
    drive_const(24'h800000, 24'h002C00);
    drive_const(24'h00FF00, model(24'h00FF00));
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) drive(1'b1, 24'($urandom_range(0, 24'hFFFFFF)));
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 24'($urandom_range(0, 24'hFFFFFF)));
      drive(1'b0, 24'($urandom_range(0, 24'hFFFFFF)));
      drive(1'b0, 24'($urandom_range(0, 24'hFFFFFF)));
    end
    drain();
  endtask

  task automatic test_hold();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 24'($urandom_range(0, 24'hFFFFFF)));
      @(negedge clk);
      n_checks++;
      if (data_out !== last_exp || enable_out !== 1'b0) begin
        n_fail++;
        $display("FAIL hold: data_out=%06h enable_out=%b required %06h/0", data_out, enable_out, last_exp);
      end
    end
  endtask

  task automatic test_reset_midflight();
    drive(1'b1, 24'h12AB34);
    drive(1'b1, 24'h9C40E0);
    // reset edge coincides with a new strobe: neither pixel may survive
    @(posedge clk);
    #1;
    rst = 1'b1;
    enable = 1'b1;
    data_in = 24'h55AA55;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    n_checks++;
    if (enable_out !== 1'b0 || data_out !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_midflight: enable_out=%b data_out=%06h required 0/000000", enable_out, data_out);
    end
    last_exp = 24'h0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 24'h0);
      @(negedge clk);
      n_checks++;
      if (enable_out !== 1'b0) begin
        n_fail++;
        $display("FAIL stale_pulse: enable_out=%b required 0 cycle %0d", enable_out, i);
      end
    end
  endtask

  task automatic test_round_trip();
    logic [23:0] p;
    for (int i = 0; i < 1000; i++) begin
      if (i == 0)      p = 24'h000000;
      else if (i == 1) p = 24'hFFFFFF;
      else             p = 24'($urandom_range(0, 24'hFFFFFF));
      rgb_q.push_back(p);
      drive(1'b1, forward(p));
      if ($urandom_range(0, 7) == 0) drive(1'b0, 24'h0);
    end
    drain();
    n_checks++;
    if (rgb_q.size() != 0) begin
      n_fail++;
      $display("FAIL round_trip_count: %0d originals unmatched, required 0", rgb_q.size());
      rgb_q.delete();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst     = 1'b1;
    enable  = 1'b0;
    data_in = 24'h0;
    test_reset();
    test_gray();
    test_clamp();
    test_back_to_back();
    test_hold();
    test_reset_midflight();
    test_round_trip();
    test_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
